// File: rtl/ula_seq_ctrl_pkg.sv
// Shared ULA definitions: opcode encodings, controller state encoding, default operand width.
// Imported by ula_seq_ctrl and ula_muldiv_iter.
// No ports (package only).
package ula_seq_ctrl_pkg;

  localparam int ULA_WIDTH = 4;

  localparam logic [2:0] OP_SOMA  = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_MULT  = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_IGUAL = 3'd4;
  localparam logic [2:0] OP_MAIOR = 3'd5;
  localparam logic [2:0] OP_MENOR = 3'd6;
  localparam logic [2:0] OP_DIF   = 3'd7;

  typedef enum logic [1:0] {
    ST_OCIOSO = 2'd0,
    ST_CALC   = 2'd1,
    ST_PRONTO = 2'd2
  } state_t;

endpackage

// File: rtl/ula_seq_ctrl_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one bit per cycle, WIDTH cycles.
// Ports: clk, rst (sync, active-high), start/is_div/a/b load a job; done is high during the
//   last iteration cycle, and result then carries the final 2*WIDTH product or {rem, quotient}.
module ula_muldiv_iter
  import ula_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH,
  parameter int CNT_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  logic               busy;
  logic [CNT_W-1:0]   cnt;
  logic               div_q;
  logic [WIDTH-1:0]   opnd_a;
  logic [WIDTH-1:0]   opnd_b;
  // mult: {partial high, remaining multiplier bits}; div: {partial remainder, dividend/quotient}
  logic [2*WIDTH-1:0] p;
  logic [2*WIDTH-1:0] p_next;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;

  always_comb begin
    mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opnd_a} : '0);
    div_shift = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_b});
    div_diff  = div_shift - {1'b0, opnd_b};
    p_next    = '0;
    if (div_q) begin
      // Restoring step: keep the subtraction only when it does not go negative.
      p_next = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]), p[WIDTH-2:0], div_ge};
    end else begin
      // Add multiplicand into the high half when the current multiplier bit is set, then shift.
      p_next = {mul_sum, p[WIDTH-1:1]};
    end
  end

  assign done   = busy && (cnt == CNT_W'(WIDTH-1));
  assign result = p_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      div_q  <= 1'b0;
      opnd_a <= '0;
      opnd_b <= '0;
      p      <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      div_q  <= is_div;
      opnd_a <= a;
      opnd_b <= b;
      p      <= is_div ? {{WIDTH{1'b0}}, a} : {{WIDTH{1'b0}}, b};
    end else if (busy) begin
      p   <= p_next;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH-1)) begin
        busy <= 1'b0;
        cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/ula_seq_ctrl.sv
// Sequencing controller for the ULA: one request per valid/ready handshake, result held until accepted.
// Ports: clk, rst (sync, active-high); req_valido/req_pronto + op/a/b request side;
//   out_valido/out_aceito + resultado/overflow/erro_div0 result side; ocupado = not idle.
module ula_seq_ctrl
  import ula_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valido,
  output logic             req_pronto,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valido,
  input  logic             out_aceito,
  output logic [WIDTH-1:0] resultado,
  output logic             overflow,
  output logic             erro_div0,
  output logic             ocupado
);

  state_t             state;
  logic               is_div_q;
  logic               md_start;
  logic               md_done;
  logic [2*WIDTH-1:0] md_res;

  // Single-cycle results, evaluated on the live inputs and captured at the accept edge.
  logic [WIDTH:0]     sum_w;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_ov;
  logic               sc_err;
  logic               needs_iter;

  always_comb begin
    sum_w  = {1'b0, a} + {1'b0, b};
    sc_res = '0;
    sc_ov  = 1'b0;
    sc_err = 1'b0;
    case (op)
      OP_SOMA: begin
        sc_res = sum_w[WIDTH-1:0];
        sc_ov  = sum_w[WIDTH];
      end
      OP_SUB: begin
        sc_res = a - b;
        sc_ov  = (a < b);
      end
      OP_DIV: begin
        // Only reached here with b == 0: saturate and flag instead of iterating.
        sc_res = '1;
        sc_err = 1'b1;
      end
      OP_IGUAL: sc_res = WIDTH'(a == b);
      OP_MAIOR: sc_res = WIDTH'(a > b);
      OP_MENOR: sc_res = WIDTH'(a < b);
      OP_DIF:   sc_res = WIDTH'(a != b);
      default: begin
        sc_res = '0;
      end
    endcase
  end

  assign needs_iter = (op == OP_MULT) || ((op == OP_DIV) && (b != '0));
  assign md_start   = (state == ST_OCIOSO) && req_valido && needs_iter;

  ula_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (md_start),
    .is_div (op == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (md_done),
    .result (md_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_OCIOSO;
      resultado  <= '0;
      overflow   <= 1'b0;
      erro_div0  <= 1'b0;
      out_valido <= 1'b0;
      req_pronto <= 1'b1;
      ocupado    <= 1'b0;
      is_div_q   <= 1'b0;
    end else begin
      case (state)
        ST_OCIOSO: begin
          if (req_valido) begin
            req_pronto <= 1'b0;
            ocupado    <= 1'b1;
            if (needs_iter) begin
              state    <= ST_CALC;
              is_div_q <= (op == OP_DIV);
            end else begin
              state      <= ST_PRONTO;
              out_valido <= 1'b1;
              resultado  <= sc_res;
              overflow   <= sc_ov;
              erro_div0  <= sc_err;
            end
          end
        end
        ST_CALC: begin
          if (md_done) begin
            state      <= ST_PRONTO;
            out_valido <= 1'b1;
            resultado  <= md_res[WIDTH-1:0];
            overflow   <= is_div_q ? 1'b0 : (md_res[2*WIDTH-1:WIDTH] != '0);
            erro_div0  <= 1'b0;
          end
        end
        ST_PRONTO: begin
          if (out_aceito) begin
            state      <= ST_OCIOSO;
            out_valido <= 1'b0;
            req_pronto <= 1'b1;
            ocupado    <= 1'b0;
          end
        end
        default: begin
          state <= ST_OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Directed testbench for ula_seq_ctrl: handshake latency, arithmetic results, backpressure, reset.
// Drives inputs #1 after the rising edge and samples outputs at the same point.
module tb_ula_seq_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valido = 1'b0;
  logic         req_pronto;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valido;
  logic         out_aceito = 1'b0;
  logic [W-1:0] resultado;
  logic         overflow;
  logic         erro_div0;
  logic         ocupado;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ula_seq_ctrl #(.WIDTH(W), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valido (req_valido),
    .req_pronto (req_pronto),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valido (out_valido),
    .out_aceito (out_aceito),
    .resultado  (resultado),
    .overflow   (overflow),
    .erro_div0  (erro_div0),
    .ocupado    (ocupado)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge; returns cycles from accept edge until out_valido seen high.
  task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, output int lat);
    chk({tag, "_rdy"}, int'(req_pronto), 1);
    op = o; a = x; b = y; req_valido = 1'b1;
    step();
    req_valido = 1'b0;
    lat = 1;
    while (!out_valido && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic consume(input string tag);
    out_aceito = 1'b1;
    step();
    out_aceito = 1'b0;
    chk({tag, "_vld_drop"}, int'(out_valido), 0);
    chk({tag, "_rdy_back"}, int'(req_pronto), 1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input int exp_lat, input int exp_res,
                        input int exp_ov, input int exp_err);
    int lat;
    issue(tag, o, x, y, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, int'(resultado), exp_res);
    chk({tag, "_ov"},  int'(overflow), exp_ov);
    chk({tag, "_err"}, int'(erro_div0), exp_err);
    consume(tag);
  endtask

  initial begin
    int lat;
    // Reset state
    rst = 1'b1;
    step();
    step();
    chk("rst_vld", int'(out_valido), 0);
    chk("rst_res", int'(resultado), 0);
    chk("rst_ov", int'(overflow), 0);
    chk("rst_err", int'(erro_div0), 0);
    chk("rst_rdy", int'(req_pronto), 1);
    chk("rst_busy", int'(ocupado), 0);
    rst = 1'b0;
    step();

    // Single-cycle and iterative operations
    run_op("soma_9_8",  3'd0, 4'd9,  4'd8, 1, 1,  1, 0);
    run_op("soma_3_4",  3'd0, 4'd3,  4'd4, 1, 7,  0, 0);
    run_op("mult_3_5",  3'd2, 4'd3,  4'd5, 5, 15, 0, 0);
    run_op("mult_5_4",  3'd2, 4'd5,  4'd4, 5, 4,  1, 0);
    run_op("mult_15_15",3'd2, 4'd15, 4'd15,5, 1,  1, 0);
    run_op("div_13_4",  3'd3, 4'd13, 4'd4, 5, 3,  0, 0);
    run_op("div_15_1",  3'd3, 4'd15, 4'd1, 5, 15, 0, 0);
    run_op("div_2_7",   3'd3, 4'd2,  4'd7, 5, 0,  0, 0);
    run_op("div_9_0",   3'd3, 4'd9,  4'd0, 1, 15, 0, 1);
    run_op("maior_7_2", 3'd5, 4'd7,  4'd2, 1, 1,  0, 0);
    run_op("menor_7_2", 3'd6, 4'd7,  4'd2, 1, 0,  0, 0);
    run_op("igual_6_6", 3'd4, 4'd6,  4'd6, 1, 1,  0, 0);
    run_op("dif_6_6",   3'd7, 4'd6,  4'd6, 1, 0,  0, 0);
    run_op("sub_2_5",   3'd1, 4'd2,  4'd5, 1, 13, 1, 0);
    run_op("sub_9_3",   3'd1, 4'd9,  4'd3, 1, 6,  0, 0);

    // out_aceito while idle has no effect
    out_aceito = 1'b1;
    step();
    out_aceito = 1'b0;
    chk("idle_aceito_rdy", int'(req_pronto), 1);
    chk("idle_aceito_vld", int'(out_valido), 0);

    // Backpressure: result held while inputs churn
    issue("bp", 3'd0, 4'd3, 4'd4, lat);
    chk("bp_lat", lat, 1);
    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      req_valido = 1'($urandom_range(0, 1));
      step();
      chk("bp_res", int'(resultado), 7);
      chk("bp_vld", int'(out_valido), 1);
      chk("bp_rdy", int'(req_pronto), 0);
      chk("bp_ov", int'(overflow), 0);
    end
    req_valido = 1'b0;
    consume("bp");

    // Reset during CALC of a divide
    op = 3'd3; a = 4'd13; b = 4'd4; req_valido = 1'b1;
    step();
    req_valido = 1'b0;
    chk("calc_rdy", int'(req_pronto), 0);
    chk("calc_busy", int'(ocupado), 1);
    step();
    step();
    chk("calc_vld", int'(out_valido), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_vld", int'(out_valido), 0);
    chk("mid_rst_res", int'(resultado), 0);
    chk("mid_rst_rdy", int'(req_pronto), 1);
    chk("mid_rst_busy", int'(ocupado), 0);
    // The abandoned divide must not surface later
    step();
    step();
    step();
    chk("mid_rst_quiet", int'(out_valido), 0);
    run_op("post_rst_soma", 3'd0, 4'd1, 4'd2, 1, 3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
